// File: rtl/core_input_arbiter.sv
// rtl/core_input_arbiter.sv - round-robin burst arbiter feeding the core input channel (optional ARB_GRANT_COUNT_EN)
module core_input_arbiter #(
    parameter int NUM_IN    = 2,
    parameter int NPC       = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_IN-1:0]          in_v,
    output logic [NUM_IN-1:0]          in_a,
    input  logic [NUM_IN*NPC-1:0]      in_d,
    output logic                       out_v,
    input  logic                       out_a,
    output logic [NPC-1:0]             out_d,
    output logic [$clog2(NUM_IN)-1:0]  out_src,
    output logic [NUM_IN*16-1:0]       grant_count
);

    localparam int IW = $clog2(NUM_IN);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   grant_idx;
    logic [7:0]      burst_cnt;
    logic            keep;
    logic            grant_valid;
    logic            can_load;
    logic            accept;

    // Cyclic search for the first requester after last_grant; last_grant itself is checked last
    always_comb begin
        int          idx;
        logic        found;
        logic [IW-1:0] idx_l;
        winner = last_grant;
        found  = 1'b0;
        idx    = 0;
        idx_l  = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            idx   = (int'(last_grant) + k) % NUM_IN;
            idx_l = IW'(idx);
            if (!found && in_v[idx_l]) begin
                winner = idx_l;
                found  = 1'b1;
            end
        end
    end

    // Grant selection: stay on the burst owner or re-arbitrate; acknowledge only when the output can load
    always_comb begin
        keep        = (state == HOLD) && in_v[last_grant] && (burst_cnt < 8'(MAX_BURST));
        grant_idx   = keep ? last_grant : winner;
        grant_valid = keep || (|in_v);
        can_load    = !out_v || out_a;
        accept      = grant_valid && can_load && reset;
        in_a        = accept ? (NUM_IN'(1) << grant_idx) : '0;
    end

    // Next state only moves on cycles where the output register can load, which freezes the grant while stalled
    always_comb begin
        state_nxt = state;
        if (can_load) begin
            state_nxt = grant_valid ? HOLD : IDLE;
        end
    end

    // Arbitration state: the burst counter restarts at one whenever a new grant begins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= IW'(NUM_IN - 1);
            burst_cnt  <= 8'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                last_grant <= grant_idx;
                burst_cnt  <= keep ? burst_cnt + 8'd1 : 8'd1;
            end
        end
    end

    // Output register loads when empty or draining, giving one word per cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_v   <= 1'b0;
            out_d   <= '0;
            out_src <= '0;
        end else if (can_load) begin
            out_v <= accept;
            if (accept) begin
                out_d   <= in_d[grant_idx*NPC +: NPC];
                out_src <= grant_idx;
            end
        end
    end

`ifdef ARB_GRANT_COUNT_EN
    genvar g;
    generate
        for (g = 0; g < NUM_IN; g++) begin : g_cnt
            logic [15:0] cnt;
            // Saturating per-source accepted-word counter
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt <= 16'd0;
                end else if (in_a[g] && in_v[g] && (cnt != 16'hFFFF)) begin
                    cnt <= cnt + 16'd1;
                end
            end
            assign grant_count[g*16 +: 16] = cnt;
        end
    endgenerate
`else
    assign grant_count = '0;
`endif

endmodule

// File: tb/tb_core_input_arbiter.sv
// tb/tb_core_input_arbiter.sv - directed self-checking bench for core_input_arbiter
module tb_core_input_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  in_v;
    logic [1:0]  in_a;
    logic [63:0] in_d;
    logic        out_v;
    logic        out_a;
    logic [31:0] out_d;
    logic [0:0]  out_src;
    logic [31:0] grant_count;

    int          checks = 0;
    int          errors = 0;
    int          seq [2];
    logic [1:0]  a_snap;

    core_input_arbiter #(.NUM_IN(2), .NPC(32), .MAX_BURST(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_v        (in_v),
        .in_a        (in_a),
        .in_d        (in_d),
        .out_v       (out_v),
        .out_a       (out_a),
        .out_d       (out_d),
        .out_src     (out_src),
        .grant_count (grant_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input int s, input int k);
        return {8'(s + 1), 24'(k)};
    endfunction

    task automatic set_data();
        for (int i = 0; i < 2; i++) in_d[i*32 +: 32] = word(i, seq[i]);
    endtask

    // One clock: snapshot acknowledges mid-cycle, then advance sources that transferred
    task automatic tick();
        logic [1:0] acc;
        @(negedge clk);
        a_snap = in_a;
        acc    = in_v & in_a;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) if (acc[i]) seq[i]++;
        set_data();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        in_v  = 2'b00;
        out_a = 1'b0;
        seq[0] = 0;
        seq[1] = 0;
        set_data();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in_v  = 2'b11;
        out_a = 1'b1;
        seq[0] = 0;
        seq[1] = 0;
        set_data();
        #12;
        checks++;
        if (out_v !== 1'b0 || out_d !== 32'd0 || out_src !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: out_v=%b out_d=%h out_src=%0d expected 0,0,0", out_v, out_d, out_src);
        end
        checks++;
        if (in_a !== 2'b00 || grant_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_ack: in_a=%b grant_count=%h expected 00, 0", in_a, grant_count);
        end
    endtask

    task automatic test_round_robin();
        int exp_src [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        int exp_k   [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 4};
        do_reset();
        in_v  = 2'b11;
        out_a = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            checks++;
            if (out_v !== 1'b1 || out_src !== 1'(exp_src[k]) || out_d !== word(exp_src[k], exp_k[k])) begin
                errors++;
                $display("FAIL round_robin[%0d]: out_v=%b out_src=%0d out_d=%h expected 1,%0d,%h",
                         k, out_v, out_src, out_d, exp_src[k], word(exp_src[k], exp_k[k]));
            end
        end
    endtask

    task automatic test_single_source();
        do_reset();
        in_v  = 2'b10;
        out_a = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (out_v !== 1'b1 || out_src !== 1'b1 || out_d !== word(1, k) || a_snap[0] !== 1'b0) begin
                errors++;
                $display("FAIL single[%0d]: out_v=%b out_src=%0d out_d=%h in_a=%b expected 1,1,%h,in_a[0]=0",
                         k, out_v, out_src, out_d, a_snap, word(1, k));
            end
        end
    endtask

    task automatic test_stall();
        int exp_src [7] = '{0, 0, 1, 1, 1, 1, 0};
        int exp_k   [7] = '{2, 3, 0, 1, 2, 3, 4};
        do_reset();
        in_v  = 2'b11;
        out_a = 1'b1;
        repeat (2) tick();
        out_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (out_v !== 1'b1 || out_d !== word(0, 1) || a_snap !== 2'b00) begin
                errors++;
                $display("FAIL stall[%0d]: out_v=%b out_d=%h in_a=%b expected 1,%h,00",
                         k, out_v, out_d, a_snap, word(0, 1));
            end
        end
        out_a = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            checks++;
            if (out_v !== 1'b1 || out_src !== 1'(exp_src[k]) || out_d !== word(exp_src[k], exp_k[k])) begin
                errors++;
                $display("FAIL stall_resume[%0d]: out_v=%b out_src=%0d out_d=%h expected 1,%0d,%h",
                         k, out_v, out_src, out_d, exp_src[k], word(exp_src[k], exp_k[k]));
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        in_v  = 2'b11;
        out_a = 1'b1;
        repeat (2) tick();
        in_v = 2'b10;
        tick();
        checks++;
        if (out_v !== 1'b1 || out_src !== 1'b1 || out_d !== word(1, 0)) begin
            errors++;
            $display("FAIL drop_switch: out_v=%b out_src=%0d out_d=%h expected 1,1,%h",
                     out_v, out_src, out_d, word(1, 0));
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_v  = 2'b11;
        out_a = 1'b1;
        repeat (2) tick();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out_v !== 1'b0 || out_src !== 1'b0 || in_a !== 2'b00) begin
            errors++;
            $display("FAIL reset_async: out_v=%b out_src=%0d in_a=%b expected 0,0,00", out_v, out_src, in_a);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        checks++;
        if (out_v !== 1'b1 || out_src !== 1'b0 || out_d !== word(0, 2)) begin
            errors++;
            $display("FAIL reset_regrant: out_v=%b out_src=%0d out_d=%h expected 1,0,%h",
                     out_v, out_src, out_d, word(0, 2));
        end
    endtask

    task automatic test_grant_count();
        do_reset();
        out_a = 1'b1;
`ifdef ARB_GRANT_COUNT_EN
        in_v = 2'b01;
        repeat (3) tick();
        in_v = 2'b10;
        repeat (5) tick();
        in_v = 2'b00;
        tick();
        checks++;
        if (grant_count !== {16'd5, 16'd3}) begin
            errors++;
            $display("FAIL grant_count: got %h expected %h", grant_count, {16'd5, 16'd3});
        end
        in_v = 2'b01;
        repeat (70000) tick();
        checks++;
        if (grant_count !== {16'd5, 16'hFFFF}) begin
            errors++;
            $display("FAIL grant_saturate: got %h expected %h", grant_count, {16'd5, 16'hFFFF});
        end
`else
        in_v = 2'b11;
        repeat (6) tick();
        checks++;
        if (grant_count !== 32'd0) begin
            errors++;
            $display("FAIL grant_tied: got %h expected 0", grant_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_source();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_grant_count();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_input_arbiter.md
Name: core_input_arbiter

Overview:
- Round-robin arbiter that shares the single 32-bit core input channel between NUM_IN word-producing sources, e.g. the router-side deserializer and the host-side PC stream.
- Each source presents complete core words in the [Code(8) | Data(24)] format.
- The block selects one source per word, with optional burst hold, and drives a registered output channel toward the core.
- It sits between the per-source deserializers and the core's input Channel.

Parameters:
- NUM_IN, 2, number of requesting sources (2..8).
- NPC, 32, core word width (Code + Data).
- MAX_BURST, 4, maximum consecutive words granted to one source before forced rotation (1..255).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- in_v  input  NUM_IN  per-source word valid.
- in_a  output  NUM_IN  per-source acknowledge; a transfer occurs on the rising clk edge when in_v[i] and in_a[i] are both high.
- in_d  input  NUM_IN*NPC  per-source words; source i occupies bits [i*NPC +: NPC].
- out_v  output  1  valid toward the core.
- out_a  input  1  core acknowledge; a transfer occurs on the clk edge when out_v and out_a are both high.
- out_d  output  NPC  word toward the core.
- out_src  output  clog2(NUM_IN)  index of the source that produced out_d.
- grant_count  output  NUM_IN*16  per-source accepted-word counters (see Optional Feature).

Behaviour:
- Reset (reset low, asynchronous): out_v=0, out_d=0, out_src=0, in_a=0, burst_cnt=0, last_grant=NUM_IN-1 (so source 0 wins first), state=IDLE.
- Output register: out_d, out_v and out_src are registered. The register can load when empty (out_v=0) or when draining in the same cycle (out_v & out_a). This gives 1 word/cycle throughput.
- in_a[i] = grant[i] & (~out_v | out_a). Combinational path from out_a to in_a is permitted; no path from in_d to in_a.
- Latency: a word accepted at edge N appears with out_v=1 after edge N; minimum one cycle.
- State machine:
  - IDLE: no grant held. Winner = first requesting index after last_grant, searching cyclically. If any in_v is high, grant the winner combinationally this cycle, load burst_cnt=1 on accept, and go to HOLD.
  - HOLD: grant stays on last_grant while in_v[last_grant]=1 and burst_cnt<MAX_BURST. Each accept increments burst_cnt.
  - Leaving HOLD: if in_v[last_grant] drops, or burst_cnt==MAX_BURST at an accept, the next cycle re-arbitrates as in IDLE, starting after last_grant. Go to IDLE if no requests, else HOLD with the new winner and burst_cnt=1.
  - An unaccepted grant (output stalled) does not advance burst_cnt or last_grant.
- Grant changes only on cycles where the output register can load. While stalled, the grant is frozen, so in_a never pulses to a non-winner.
- At most one in_a bit is high in any cycle. in_a[i] is never high while in_v[i] is low.
- Single requester: streams continuously. MAX_BURST expiry re-arbitrates to the same source with no bubble.
- Simultaneous out_a and new accept: the old word leaves and the new word loads on the same edge, so out_v stays 1.
- Reset mid-transfer: any word held in the output register is discarded. Sources must retain un-acked words.
- out_d holds its value when out_v=0; no X propagation.

Optional Feature:
- Macro: ARB_GRANT_COUNT_EN.
- Defined: each grant_count[i] is a 16-bit counter incremented on every accepted word from source i. It saturates at 16'hFFFF and clears only on reset.
- Undefined: counters are not instantiated and grant_count is tied to 0.

Test Plan:
- Reset, then sources 0 and 1 continuously valid, MAX_BURST=4, out_a=1 → out_src sequence 0,0,0,0,1,1,1,1,0; one word/cycle, no gaps.
- Only source 1 valid, 10 words, out_a=1 → 10 consecutive out_v cycles, out_src=1 throughout, in_a[0] never high.
- Output stall: out_a=0 for 5 cycles with both sources valid → out_v=1 and out_d held constant, in_a=0, grant frozen; on release, order resumes correctly.
- Source 0 drops in_v after 2 words of a burst → next accepted word comes from source 1 with no idle cycle.
- Assert reset low while out_v=1 and the burst is mid-way → out_v=0 immediately (asynchronous), and the next grant after release goes to source 0.
- ARB_GRANT_COUNT_EN defined, 3 words from source 0 and 5 words from source 1 → grant_count = {16'd5, 16'd3}; force 70000 accepts from source 0 → its counter saturates at 16'hFFFF.
